// File: rtl/vga_scan_gen.sv
// 320x200 video timing and pixel-fetch stage: RAM address generation, RGB332 re-timing, syncs, frame strobe.
// Define VGA_DOUBLESCAN_EN to emit every logical line twice (422 scanlines); undefined gives 211 scanlines.
module vga_scan_gen #(
    parameter int H_ACTIVE     = 320,
    parameter int H_SYNC_START = 352,
    parameter int H_SYNC_END   = 368,
    parameter int H_TOTAL      = 400,
    parameter int V_ACTIVE     = 200,
    parameter int V_SYNC_START = 204,
    parameter int V_SYNC_END   = 207,
    parameter int V_TOTAL      = 211,
    parameter bit HSYNC_POL    = 1'b0,
    parameter bit VSYNC_POL    = 1'b0
) (
    input  logic        CLK,
    input  logic        R,
    input  logic [7:0]  pix_i,
    output logic [15:0] addr_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [7:0]  rgb_o,
    output logic        frame_o
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_SYNC_START);
    localparam logic [HW-1:0] H_SE   = HW'(H_SYNC_END);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_SYNC_START);
    localparam logic [VW-1:0] V_SE   = VW'(V_SYNC_END);

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic frame;
    } ctl_t;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          s;
    ctl_t          cur;
    ctl_t          st1;

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge CLK) begin
        if (R) begin
            h <= '0;
            v <= '0;
            s <= 1'b0;
        end else if (h == H_LAST) begin
            h <= '0;
`ifdef VGA_DOUBLESCAN_EN
            s <= ~s;
            if (s)
                v <= (v == V_LAST) ? '0 : v + 1'b1;
`else
            s <= 1'b0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
`endif
        end else begin
            h <= h + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cur       = '0;
        addr_o    = '0;
        cur.de    = (h < H_ACT) && (v < V_ACT);
        cur.hs    = (h >= H_SS) && (h < H_SE);
        cur.vs    = (v >= V_SS) && (v < V_SE);
        cur.frame = (h == '0) && (v == V_ACT) && !s;
        // Constant multiply folds to (v<<8)+(v<<6) for the 320-wide mode.
        if (cur.de)
            addr_o = 16'(v) * 16'(H_ACTIVE) + 16'(h);
    end

    // Stage 1 waits for the RAM's one-cycle read; stage 2 joins control with the returned pixel.
    always_ff @(posedge CLK) begin
        if (R) begin
            st1     <= '0;
            de_o    <= 1'b0;
            rgb_o   <= 8'h00;
            hsync_o <= ~HSYNC_POL;
            vsync_o <= ~VSYNC_POL;
            frame_o <= 1'b0;
        end else begin
            st1     <= cur;
            de_o    <= st1.de;
            rgb_o   <= st1.de ? pix_i : 8'h00;
            hsync_o <= st1.hs ? HSYNC_POL : ~HSYNC_POL;
            vsync_o <= st1.vs ? VSYNC_POL : ~VSYNC_POL;
            frame_o <= st1.frame;
        end
    end

endmodule
